mixcol_scale_arbiter: RTL and testbench
=======================================

// Module: mixcol_scale_arbiter
// PURPOSE
//   Shares one scaling_factors instance (GF(2^8) constant multipliers x2A, x2B, x49, x0A) between
//   NUM_REQ byte requesters, e.g. the four MixColumns column lanes of the AES IP.
//   Round-robin arbitration feeds a 2-stage pipeline around scaling_factors; the stages are
//   S1 (operand register) and S2 (product register).
//   Each result returns with the requester's ID under valid/ready backpressure.
//   Full throughput: one byte per cycle.
// PARAMETERS
//   NUM_REQ   4   number of requesters, 2..8
//   ID_W      2   width of out_id; must be >= clog2(NUM_REQ)
//   CNT_W     16  width of the completed-operation counter
// PORTS
//   clk         in   1            single clock, rising edge
//   rst_n       in   1            reset, synchronous, active-low
//   req_valid   in   NUM_REQ      per-requester operand valid
//   req_data    in   8*NUM_REQ    operand byte; requester i on bits [8i+7:8i]
//   req_ready   out  NUM_REQ      one-hot grant; a transfer occurs when req_valid[i] & req_ready[i]
//   out_valid   out  1            product bundle valid (S2 occupied)
//   out_ready   in   1            downstream accepts bundle
//   out_id      out  ID_W         index of the requester that supplied the operand
//   out_2a      out  8            s * 0x2A
//   out_2b      out  8            s * 0x2B
//   out_49      out  8            s * 0x49
//   out_a       out  8            s * 0x0A
//   busy        out  1            S1 or S2 occupied
//   op_cnt      out  CNT_W        count of completed output handshakes
// BEHAVIOUR
//   Reset (rst_n low at a clk edge):
//     - outputs: out_valid=0, all out_* data and out_id=0, op_cnt=0, busy=0
//     - S1 is cleared; rr_ptr=NUM_REQ-1, so requester 0 has top priority first
//     - in-flight data is discarded, not drained
//     - req_ready is forced 0 during reset
//   Stage enables:
//     - s2_en = !out_valid | out_ready
//     - s1_adv = s1_v & s2_en
//     - s1_free = !s1_v | s1_adv
//   Arbitration (combinational):
//     - when s1_free, grant the first i with req_valid[i], scanning from rr_ptr+1 mod NUM_REQ
//     - req_ready has at most one bit set; it is all-zero when !s1_free or when no request is pending
//     - req_ready does not depend on req_valid of non-granted requesters beyond the priority scan
//     - requesters must hold req_valid and req_data stable until their handshake
//   On a grant handshake:
//     - S1 captures the operand byte and the ID; s1_v=1
//     - rr_ptr updates to the granted index
//     - with no handshake, rr_ptr holds
//   If s1_adv and there is no new grant, s1_v clears.
//   S2 datapath:
//     - when s1_adv, S2 loads scaling_factors(S1 byte) and the S1 ID, and out_valid=1
//     - when out_valid & out_ready and there is no s1_adv, out_valid clears
//   Latency: grant at edge k gives out_valid at edge k+1 (the S2 load following the S1 capture).
//     - requester to output: 2 register stages
//     - minimum: 1 cycle between the S1 capture and out_valid
//   Backpressure:
//     - out_ready=0 holds all out_* stable
//     - S1 holds one further operand; after that, req_ready=0 for all requesters
//     - at most 2 operands in flight
//   Simultaneous output handshake and S1 advance: S2 reloads in the same cycle with no bubble.
//   Products are pure functions of the byte; no state is carried between operations.
//   op_cnt increments by 1 on each out_valid & out_ready and wraps at 2^CNT_W-1 -> 0.
//   busy = s1_v | out_valid.
//   Requesters with index >= NUM_REQ do not exist; out_id never exceeds NUM_REQ-1.
// TESTING
//   1. Reset: hold rst_n=0 for 3 clks with all req_valid=1.
//      -> req_ready=0, out_valid=0, op_cnt=0 throughout.
//      After release, the first grant goes to req 0.
//   2. Single op: req 1 sends 0x01 with out_ready=1.
//      -> 2 clks later out_valid=1, out_id=1, out_2a=0x2A, out_2b=0x2B, out_49=0x49, out_a=0x0A.
//      Sending 0x00 -> all products 0x00.
//   3. Round-robin fairness: all 4 requesters valid continuously, out_ready=1.
//      -> grants cycle 0,1,2,3,0,... one per clk; out_id follows the same sequence.
//      op_cnt=8 after 8 results.
//   4. Backpressure: out_ready=0 with 3 requests pending.
//      -> exactly 2 accepted; req_ready=0 afterwards; out_* stable.
//      Raise out_ready -> both results emitted in order on consecutive clks, then the third is granted.
//   5. Linearity check vs model: random bytes a, b.
//      -> product(a^b) == product(a)^product(b) for all four outputs.
//      Results match the scaling_factors golden model.
//   6. Mid-operation reset: assert rst_n=0 with both stages full.
//      -> next clk out_valid=0, busy=0, no stale output.
//      Counter wrap with CNT_W=4: 17 handshakes -> op_cnt=1.

Source files
------------

// File: rtl/mixcol_scale_arbiter.sv
// Round-robin share of one GF(2^8) x2A/x2B/x49/x0A multiplier among NUM_REQ byte requesters.
// Two register stages (operand S1, product S2); one op per cycle; out_ready=0 stalls S2, S1 takes one more, then req_ready drops.
module mixcol_scale_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ID_W-1:0]      out_id,
    output logic [7:0]           out_2a,
    output logic [7:0]           out_2b,
    output logic [7:0]           out_49,
    output logic [7:0]           out_a,
    output logic                 busy,
    output logic [CNT_W-1:0]     op_cnt
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int SW    = PTR_W + 1;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] k);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (k[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    logic               r_s1_v;
    logic [7:0]         r_s1_dat;
    logic [ID_W-1:0]    r_s1_id;
    logic               r_out_valid;
    logic [ID_W-1:0]    r_out_id;
    logic [7:0]         r_2a, r_2b, r_49, r_a;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]   r_op_cnt;

    logic               w_s2_en, w_s1_adv, w_s1_free, w_hs;
    logic               w_gnt_found;
    logic [PTR_W-1:0]   w_gnt_idx;
    logic [SW-1:0]      w_sum;
    logic [PTR_W-1:0]   w_idx;
    logic [NUM_REQ-1:0] w_grant;
    logic [7:0]         w_gnt_dat;

    assign w_s2_en   = !r_out_valid | out_ready;
    assign w_s1_adv  = r_s1_v & w_s2_en;
    assign w_s1_free = !r_s1_v | w_s1_adv;

    // Scan starts one past the last winner so the previous grantee has lowest priority.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_sum       = '0;
        w_idx       = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_sum = {1'b0, r_rr_ptr} + SW'(off);
            if (w_sum >= SW'(NUM_REQ)) w_sum = w_sum - SW'(NUM_REQ);
            w_idx = w_sum[PTR_W-1:0];
            if (!w_gnt_found && req_valid[w_idx]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_idx;
            end
        end
    end

    always_comb begin
        w_grant = '0;
        if (w_gnt_found && w_s1_free) w_grant[w_gnt_idx] = 1'b1;
    end

    assign w_hs      = w_gnt_found & w_s1_free;
    assign w_gnt_dat = req_data[{w_gnt_idx, 3'b000} +: 8];
    assign req_ready = rst_n ? w_grant : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_v      <= 1'b0;
            r_s1_dat    <= 8'h00;
            r_s1_id     <= '0;
            r_out_valid <= 1'b0;
            r_out_id    <= '0;
            r_2a        <= 8'h00;
            r_2b        <= 8'h00;
            r_49        <= 8'h00;
            r_a         <= 8'h00;
            r_rr_ptr    <= PTR_W'(NUM_REQ - 1);
            r_op_cnt    <= '0;
        end else begin
            if (w_hs) begin
                r_s1_v   <= 1'b1;
                r_s1_dat <= w_gnt_dat;
                r_s1_id  <= ID_W'(w_gnt_idx);
                r_rr_ptr <= w_gnt_idx;
            end else if (w_s1_adv) begin
                r_s1_v <= 1'b0;
            end

            // S2 reloads on the same edge it is drained, so back-to-back ops leave no bubble.
            if (w_s1_adv) begin
                r_out_valid <= 1'b1;
                r_out_id    <= r_s1_id;
                r_2a        <= gmul(r_s1_dat, 8'h2A);
                r_2b        <= gmul(r_s1_dat, 8'h2B);
                r_49        <= gmul(r_s1_dat, 8'h49);
                r_a         <= gmul(r_s1_dat, 8'h0A);
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (r_out_valid && out_ready) r_op_cnt <= r_op_cnt + CNT_W'(1);
        end
    end

    assign out_valid = r_out_valid;
    assign out_id    = r_out_id;
    assign out_2a    = r_2a;
    assign out_2b    = r_2b;
    assign out_49    = r_49;
    assign out_a     = r_a;
    assign busy      = r_s1_v | r_out_valid;
    assign op_cnt    = r_op_cnt;

endmodule

// File: tb/tb_mixcol_scale_arbiter.sv
// Directed bench for mixcol_scale_arbiter: reset, single ops, round-robin, backpressure, mid-op reset, counter wrap.
module tb_mixcol_scale_arbiter;

    localparam int NR  = 4;
    localparam int IDW = 2;
    localparam int CW  = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic            out_valid;
    logic            out_ready;
    logic [IDW-1:0]  out_id;
    logic [7:0]      out_2a, out_2b, out_49, out_a;
    logic            busy;
    logic [CW-1:0]   op_cnt;

    int n_cmp   = 0;
    int n_bad   = 0;
    int exp_cnt = 0;

    mixcol_scale_arbiter #(.NUM_REQ(NR), .ID_W(IDW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_2a    (out_2a),
        .out_2b    (out_2b),
        .out_49    (out_49),
        .out_a     (out_a),
        .busy      (busy),
        .op_cnt    (op_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Carry-less product followed by polynomial reduction by 0x11B.
    function automatic logic [7:0] gf(input logic [7:0] a, input logic [7:0] k);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (k[i]) p = p ^ (15'(a) << i);
        for (int b = 14; b >= 8; b--)
            if (p[b]) p = p ^ (15'(9'h11B) << (b - 8));
        return p[7:0];
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_op(input int idx, input logic [7:0] b,
                         input logic [7:0] e2a, input logic [7:0] e2b,
                         input logic [7:0] e49, input logic [7:0] ea);
        req_data[8*idx +: 8] = b;
        req_valid            = '0;
        req_valid[idx]       = 1'b1;
        #1;
        chk("op.grant", req_ready, 32'(1) << idx);
        step();
        req_valid = '0;
        chk("op.s1_busy", busy, 1);
        chk("op.s1_no_out", out_valid, 0);
        step();
        chk("op.out_valid", out_valid, 1);
        chk("op.out_id", out_id, idx);
        chk("op.2a", out_2a, e2a);
        chk("op.2b", out_2b, e2b);
        chk("op.49", out_49, e49);
        chk("op.0a", out_a, ea);
        step();
        exp_cnt++;
        chk("op.drained", out_valid, 0);
        chk("op.cnt", op_cnt, exp_cnt % 16);
    endtask

    // All four requesters valid continuously; assumes the arbiter last granted requester 3.
    task automatic stream(input int n);
        for (int j = 0; j < NR; j++) req_data[8*j +: 8] = 8'h10 + 8'(j);
        for (int i = 0; i < n + 2; i++) begin
            req_valid = (i < n) ? 4'hF : 4'h0;
            #1;
            if (i < n) chk("rr.grant", req_ready, 32'(1) << (i % 4));
            if (i >= 2) begin
                chk("rr.out_valid", out_valid, 1);
                chk("rr.out_id", out_id, (i - 2) % 4);
                chk("rr.2a", out_2a, gf(8'h10 + 8'((i - 2) % 4), 8'h2A));
                exp_cnt++;
            end
            step();
        end
        chk("rr.idle", out_valid, 0);
        chk("rr.busy", busy, 0);
        chk("rr.cnt", op_cnt, exp_cnt % 16);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step();
        rst_n   = 1'b1;
        exp_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a, b, c;
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_data  = 32'hA5A5A5A5;
        out_ready = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst.req_ready", req_ready, 0);
            chk("rst.out_valid", out_valid, 0);
            chk("rst.op_cnt", op_cnt, 0);
            chk("rst.busy", busy, 0);
        end
        rst_n = 1'b1;
        #1;
        chk("rst.first_grant", req_ready, 4'b0001);
        req_valid = '0;
        step();

        do_op(1, 8'h01, 8'h2A, 8'h2B, 8'h49, 8'h0A);
        do_op(2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        do_op(3, 8'h02, 8'h54, 8'h56, 8'h92, 8'h14);
        do_op(0, 8'h80, 8'hDC, 8'h5C, 8'hA1, 8'h77);

        for (int k = 0; k < 3; k++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            c = a ^ b;
            do_op(k, a, gf(a, 8'h2A), gf(a, 8'h2B), gf(a, 8'h49), gf(a, 8'h0A));
            do_op(k + 1, b, gf(b, 8'h2A), gf(b, 8'h2B), gf(b, 8'h49), gf(b, 8'h0A));
            do_op(k, c, gf(a, 8'h2A) ^ gf(b, 8'h2A), gf(a, 8'h2B) ^ gf(b, 8'h2B),
                  gf(a, 8'h49) ^ gf(b, 8'h49), gf(a, 8'h0A) ^ gf(b, 8'h0A));
        end

        pulse_reset();
        stream(8);

        out_ready = 1'b0;
        req_data  = 32'h00_C3_B2_A1;
        req_valid = 4'b0111;
        #1;
        chk("bp.grant0", req_ready, 4'b0001);
        step();
        req_valid = 4'b0110;
        #1;
        chk("bp.grant1", req_ready, 4'b0010);
        step();
        req_valid = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp.blocked", req_ready, 0);
            chk("bp.out_valid", out_valid, 1);
            chk("bp.out_id", out_id, 0);
            chk("bp.2a_stable", out_2a, gf(8'hA1, 8'h2A));
            chk("bp.busy", busy, 1);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp.grant2", req_ready, 4'b0100);
        step();
        req_valid = '0;
        chk("bp.res1_valid", out_valid, 1);
        chk("bp.res1_id", out_id, 1);
        chk("bp.res1_49", out_49, gf(8'hB2, 8'h49));
        step();
        chk("bp.res2_valid", out_valid, 1);
        chk("bp.res2_id", out_id, 2);
        chk("bp.res2_0a", out_a, gf(8'hC3, 8'h0A));
        step();
        exp_cnt += 3;
        chk("bp.idle", out_valid, 0);
        chk("bp.cnt", op_cnt, exp_cnt % 16);

        out_ready = 1'b0;
        req_valid = 4'b0001;
        step();
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        chk("mrst.full_busy", busy, 1);
        chk("mrst.full_valid", out_valid, 1);
        rst_n     = 1'b0;
        req_valid = 4'hF;
        #1;
        chk("mrst.ready_low", req_ready, 0);
        step();
        chk("mrst.out_valid", out_valid, 0);
        chk("mrst.busy", busy, 0);
        chk("mrst.op_cnt", op_cnt, 0);
        rst_n     = 1'b1;
        req_valid = '0;
        out_ready = 1'b1;
        exp_cnt   = 0;
        step();
        chk("mrst.no_stale", out_valid, 0);
        chk("mrst.still_idle", busy, 0);

        stream(17);
        chk("wrap.cnt17", op_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
